// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state type,
// default operand width and a counter-sizing helper.
package serial_add_pkg;

    // Operand width used when the instantiating code does not override it.
    localparam int unsigned DEFAULT_WIDTH = 8;

    // Controller states: waiting, shifting bits through the adder cell, result valid.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits needed for a counter that must hold values 0..width without wrapping.
    function automatic int unsigned cnt_bits(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_add_ctrl_full_adder.sv
// One-bit full-adder cell; the serial controller reuses this single cell for
// every bit position of the operands.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic half_sum;

    // Pure combinational sum/carry of three input bits.
    always_comb begin
        half_sum = a ^ b;
        s        = half_sum ^ cin;
        cout     = (a & b) | (cin & half_sum);
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: captures two WIDTH-bit operands and a carry-in,
// then feeds them LSB first through one full-adder cell, one bit per clock.
// Optional feature: define SERIAL_ADD_OVF_EN to add the signed-overflow output ovf.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned   CW   = cnt_bits(WIDTH);
    // Counter value during the final RUN cycle; counting stops there, so it never wraps.
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             fa_s;
    logic             fa_c;
    logic [WIDTH-1:0] res_nxt;

    // The single adder cell always sees the current operand LSBs and the carry register.
    full_adder u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_c)
    );

    // Result register after this cycle's sum bit enters from the MSB side.
    always_comb begin
        res_nxt = {fa_s, res_sh[WIDTH-1:1]};
    end

    // Sequencing FSM with registered status and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf    <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    // start is deliberately not looked at here.
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= res_nxt;
                    carry  <= fa_c;
                    if (cnt == LAST) begin
                        sum   <= res_nxt;
                        cout  <= fa_c;
`ifdef SERIAL_ADD_OVF_EN
                        // carry holds the carry into the MSB on this last cycle.
                        ovf   <= carry ^ fa_c;
`endif
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    // busy and done mirror the RUN and DONE states and are never high together.
    assert property (@(posedge clk) disable iff (!rst_n) busy == (state == RUN));
    assert property (@(posedge clk) disable iff (!rst_n) done == (state == DONE));
    assert property (@(posedge clk) disable iff (!rst_n) !(busy && done));
    // done is a single-cycle pulse.
    assert property (@(posedge clk) disable iff (!rst_n) done |=> !done);
    // Counter stays within the range of bit positions.
    assert property (@(posedge clk) disable iff (!rst_n) cnt <= LAST);
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: directed cases, ignored start, mid-run reset,
// back-to-back starts and randomized operands against an arithmetic reference model.
module tb_serial_add_ctrl;

    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             cin = 1'b0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf;
`endif

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    // Reference: plain unsigned addition, carry-out as bit WIDTH.
    function automatic logic [WIDTH:0] model_add(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y,
                                                 input logic c);
        return {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
    endfunction

    // Reference: signed overflow when like-signed operands give an opposite-signed result.
    function automatic logic model_ovf(input logic [WIDTH-1:0] x,
                                       input logic [WIDTH-1:0] y,
                                       input logic c);
        logic [WIDTH:0] r;
        r = model_add(x, y, c);
        return (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
    endfunction

    // Drive one start pulse; returns at the sample point of the first cycle after acceptance.
    task automatic issue(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                         input logic ic);
        @(negedge clk);
        start = 1'b1;
        a     = ia;
        b     = ib;
        cin   = ic;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_total++;
        if ({busy, done, sum, cout} !== '0)
            $display("FAIL reset_outputs: got busy=%b done=%b sum=%h cout=%b want all 0",
                     busy, done, sum, cout);
        else n_pass++;
`ifdef SERIAL_ADD_OVF_EN
        n_total++;
        if (ovf !== 1'b0) $display("FAIL reset_ovf: got %b want 0", ovf);
        else n_pass++;
`endif
        rst_n = 1'b1;
        @(negedge clk);
        n_total++;
        if ({busy, done} !== 2'b00)
            $display("FAIL idle_after_reset: got busy=%b done=%b want 0 0", busy, done);
        else n_pass++;
    endtask

    task automatic test_directed();
        logic [7:0] va [5] = '{8'h0F, 8'hFF, 8'hFF, 8'h7F, 8'h80};
        logic [7:0] vb [5] = '{8'h01, 8'h01, 8'hFF, 8'h01, 8'h80};
        logic       vc [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [7:0] vs [5] = '{8'h10, 8'h00, 8'hFF, 8'h80, 8'h00};
        logic       vo [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic       vv [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int v = 0; v < 5; v++) begin
            issue(va[v], vb[v], vc[v]);
            for (int cyc = 1; cyc <= int'(WIDTH); cyc++) begin
                n_total++;
                if ({busy, done} !== 2'b10)
                    $display("FAIL dir%0d_busy_cycle%0d: got busy=%b done=%b want 1 0",
                             v, cyc, busy, done);
                else n_pass++;
                @(negedge clk);
            end
            n_total++;
            if ({busy, done} !== 2'b01)
                $display("FAIL dir%0d_done: got busy=%b done=%b want 0 1", v, busy, done);
            else n_pass++;
            n_total++;
            if ({cout, sum} !== {vo[v], vs[v]})
                $display("FAIL dir%0d_result: got cout=%b sum=%h want cout=%b sum=%h",
                         v, cout, sum, vo[v], vs[v]);
            else n_pass++;
`ifdef SERIAL_ADD_OVF_EN
            n_total++;
            if (ovf !== vv[v]) $display("FAIL dir%0d_ovf: got %b want %b", v, ovf, vv[v]);
            else n_pass++;
`else
            if (vv[v] === 1'bx) $display("unexpected table entry %0d", v);
`endif
            @(negedge clk);
            n_total++;
            if ({busy, done, cout, sum} !== {2'b00, vo[v], vs[v]})
                $display("FAIL dir%0d_hold: got busy=%b done=%b cout=%b sum=%h want 0 0 %b %h",
                         v, busy, done, cout, sum, vo[v], vs[v]);
            else n_pass++;
        end
    endtask

    task automatic test_ignore_start();
        issue(8'h12, 8'h34, 1'b0);
        for (int cyc = 1; cyc <= int'(WIDTH); cyc++) begin
            n_total++;
            if ({busy, done} !== 2'b10)
                $display("FAIL ign_busy_cycle%0d: got busy=%b done=%b want 1 0", cyc, busy, done);
            else n_pass++;
            if (cyc == 3) begin
                start = 1'b1;
                a     = 8'h55;
            end
            if (cyc == 4) start = 1'b0;
            @(negedge clk);
        end
        n_total++;
        if ({done, cout, sum} !== {1'b1, 1'b0, 8'h46})
            $display("FAIL ign_result: got done=%b cout=%b sum=%h want 1 0 46", done, cout, sum);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        issue(8'hAB, 8'hCD, 1'b1);
        for (int cyc = 1; cyc <= 4; cyc++) begin
            n_total++;
            if (busy !== 1'b1) $display("FAIL rst_pre_busy%0d: got %b want 1", cyc, busy);
            else n_pass++;
            @(negedge clk);
        end
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if ({busy, done, sum, cout} !== '0)
            $display("FAIL rst_mid_outputs: got busy=%b done=%b sum=%h cout=%b want all 0",
                     busy, done, sum, cout);
        else n_pass++;
`ifdef SERIAL_ADD_OVF_EN
        n_total++;
        if (ovf !== 1'b0) $display("FAIL rst_mid_ovf: got %b want 0", ovf);
        else n_pass++;
`endif
        // Release just before a rising edge with start already high.
        #1;
        rst_n = 1'b1;
        start = 1'b1;
        a     = 8'h01;
        b     = 8'h02;
        cin   = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc <= int'(WIDTH); cyc++) begin
            n_total++;
            if ({busy, done} !== 2'b10)
                $display("FAIL rst_post_busy%0d: got busy=%b done=%b want 1 0", cyc, busy, done);
            else n_pass++;
            @(negedge clk);
        end
        n_total++;
        if ({done, cout, sum} !== {1'b1, 1'b0, 8'h03})
            $display("FAIL rst_post_result: got done=%b cout=%b sum=%h want 1 0 03",
                     done, cout, sum);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [WIDTH:0] exp1;
        logic [WIDTH:0] exp2;
        exp1 = model_add(8'h3C, 8'h0A, 1'b1);
        exp2 = model_add(8'hF0, 8'h20, 1'b0);
        issue(8'h3C, 8'h0A, 1'b1);
        for (int cyc = 1; cyc <= int'(WIDTH); cyc++) begin
            n_total++;
            if ({busy, done} !== 2'b10)
                $display("FAIL b2b_first_busy%0d: got busy=%b done=%b want 1 0", cyc, busy, done);
            else n_pass++;
            if (cyc == int'(WIDTH)) begin
                start = 1'b1;
                a     = 8'hF0;
                b     = 8'h20;
                cin   = 1'b0;
            end
            @(negedge clk);
        end
        n_total++;
        if ({done, cout, sum} !== {1'b1, exp1})
            $display("FAIL b2b_first_result: got done=%b cout=%b sum=%h want 1 %b %h",
                     done, cout, sum, exp1[WIDTH], exp1[WIDTH-1:0]);
        else n_pass++;
        @(negedge clk);
        start = 1'b0;
        n_total++;
        if ({busy, done} !== 2'b10)
            $display("FAIL b2b_no_idle: got busy=%b done=%b want 1 0", busy, done);
        else n_pass++;
        for (int cyc = 2; cyc <= int'(WIDTH); cyc++) begin
            @(negedge clk);
            n_total++;
            if ({busy, done} !== 2'b10)
                $display("FAIL b2b_second_busy%0d: got busy=%b done=%b want 1 0", cyc, busy, done);
            else n_pass++;
        end
        @(negedge clk);
        n_total++;
        if ({done, cout, sum} !== {1'b1, exp2})
            $display("FAIL b2b_second_result: got done=%b cout=%b sum=%h want 1 %b %h",
                     done, cout, sum, exp2[WIDTH], exp2[WIDTH-1:0]);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic             rc;
        logic [WIDTH:0]   exp;
        int unsigned      busy_bad;
        for (int n = 0; n < 40; n++) begin
            ra  = WIDTH'($urandom);
            rb  = WIDTH'($urandom);
            rc  = 1'($urandom);
            exp = model_add(ra, rb, rc);
            issue(ra, rb, rc);
            busy_bad = 0;
            for (int cyc = 1; cyc <= int'(WIDTH); cyc++) begin
                if ({busy, done} !== 2'b10) busy_bad++;
                @(negedge clk);
            end
            n_total++;
            if (busy_bad != 0)
                $display("FAIL rnd%0d_busy: got %0d bad RUN cycles want 0", n, busy_bad);
            else n_pass++;
            n_total++;
            if ({done, cout, sum} !== {1'b1, exp})
                $display("FAIL rnd%0d_result %h+%h+%b: got done=%b cout=%b sum=%h want 1 %b %h",
                         n, ra, rb, rc, done, cout, sum, exp[WIDTH], exp[WIDTH-1:0]);
            else n_pass++;
`ifdef SERIAL_ADD_OVF_EN
            n_total++;
            if (ovf !== model_ovf(ra, rb, rc))
                $display("FAIL rnd%0d_ovf: got %b want %b", n, ovf, model_ovf(ra, rb, rc));
            else n_pass++;
`endif
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_start();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_total);
        $fatal(1);
    end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (legal 2..32).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port start  input  1  request to begin one addition.
REQ-005 SHALL have port a  input  WIDTH  operand A.
REQ-006 SHALL have port b  input  WIDTH  operand B.
REQ-007 SHALL have port cin  input  1  initial carry-in.
REQ-008 SHALL have port busy  output  1  high while bits are being processed.
REQ-009 SHALL have port done  output  1  one-cycle pulse when the result is valid.
REQ-010 SHALL have port sum  output  WIDTH  result, held until the next accepted start.
REQ-011 SHALL have port cout  output  1  final carry-out, held like sum.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-013 SHALL, in IDLE or DONE with start=1, capture a, b and cin into internal registers, clear the bit counter, and enter RUN.
REQ-014 SHALL ignore start while in RUN; captured operands stay unchanged.
REQ-015 SHALL, in RUN, process one bit per cycle, LSB first, through a single one-bit full-adder cell fed by the shifted operand LSBs and the carry register.
REQ-016 SHALL, on each RUN cycle, shift the sum bit into the result register MSB side and update the carry register with the cell carry-out.
REQ-017 SHALL stay in RUN for exactly WIDTH cycles, then enter DONE.
REQ-018 SHALL drive busy=1 exactly in RUN; done=1 exactly in DONE.
REQ-019 SHALL update sum and cout on the edge entering DONE; start accepted at edge k gives done high in cycle k+WIDTH+1.
REQ-020 SHALL return from DONE to IDLE after one cycle when start=0; back-to-back start in DONE goes directly to RUN without an IDLE cycle.
REQ-021 SHALL produce sum/cout equal to {cout,sum} = a + b + cin, all arithmetic unsigned, carry wrapping beyond WIDTH+1 impossible by construction.
REQ-022 SHALL size the bit counter to $clog2(WIDTH+1) bits; counter never wraps.

Reset
REQ-023 SHALL, on rst_n low at any time including mid-RUN, asynchronously force state IDLE, busy=0, done=0, sum=0, cout=0, carry and counter to 0; the partial result is discarded.
REQ-024 SHALL accept a new start on the first rising edge after rst_n deasserts.

Configuration
REQ-025 SHALL, with macro SERIAL_ADD_OVF_EN defined, add output ovf (1 bit) = signed two's-complement overflow (carry into MSB XOR carry out of MSB), updated and held like sum, reset 0.
REQ-026 SHALL, without SERIAL_ADD_OVF_EN, have no ovf port and no extra logic; all other behaviour identical.

Structure
REQ-027 SHALL place the state enum (IDLE, RUN, DONE) and the default-WIDTH constant in shared package serial_add_pkg.
REQ-028 SHALL instantiate exactly one sub-module, full_adder (one-bit sum/carry cell); all sequencing lives in serial_add_ctrl.

Verification
REQ-029 SHALL cover: WIDTH=8, a=0x0F, b=0x01, cin=0 -> sum=0x10, cout=0, done in cycle k+9, busy high cycles k+1..k+8.
REQ-030 SHALL cover: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-031 SHALL cover: start pulsed with a=0x55 during RUN of 0x12+0x34 -> ignored, result 0x46, cout=0.
REQ-032 SHALL cover: rst_n low at RUN bit 4 -> outputs 0 immediately, IDLE; next start 0x01+0x02 -> sum=0x03.
REQ-033 SHALL cover: start held high in DONE -> new RUN next cycle, no IDLE, second result correct.
REQ-034 SHALL cover (SERIAL_ADD_OVF_EN): a=0x7F, b=0x01, cin=0 -> sum=0x80, ovf=1; a=0x80, b=0x80 -> sum=0x00, cout=1, ovf=1.
